// File: rtl/piece_move_animator.sv
// Sprite origin animator: accepts a square-to-square move and glides the
// 55x55 piece origin toward the destination by up to STEP pixels per frame.
module piece_move_animator #(
    parameter int BOARD_X0 = 80,
    parameter int BOARD_Y0 = 0,
    parameter int SQ       = 60,
    parameter int PAD      = 2,
    parameter int STEP     = 4
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [2:0] src_col,
    input  logic [2:0] src_row,
    input  logic [2:0] dst_col,
    input  logic [2:0] dst_row,
    output logic [9:0] offsetX,
    output logic [9:0] offsetY,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [9:0] STEP_W = 10'(STEP);
    localparam logic [9:0] OX0    = 10'(BOARD_X0 + PAD);
    localparam logic [9:0] OY0    = 10'(BOARD_Y0 + PAD);

    state_t     state_q, state_d;
    logic [9:0] px_q, px_d;
    logic [9:0] py_q, py_d;
    logic [9:0] tx_q, tx_d;
    logic [9:0] ty_q, ty_d;
    logic [9:0] nx, ny;
    logic       accept;
    logic       arrive;

    function automatic logic [9:0] ox(input logic [2:0] c);
        ox = 10'(BOARD_X0 + PAD + int'(c) * SQ);
    endfunction

    function automatic logic [9:0] oy(input logic [2:0] r);
        oy = 10'(BOARD_Y0 + PAD + int'(r) * SQ);
    endfunction

    // Compare first, then subtract: no signed math, so no wrap is possible.
    function automatic logic [9:0] step_axis(
        input logic [9:0] p,
        input logic [9:0] t
    );
        logic [9:0] d;
        if (t > p) begin
            d = t - p;
            step_axis = (d > STEP_W) ? p + STEP_W : t;
        end else begin
            d = p - t;
            step_axis = (d > STEP_W) ? p - STEP_W : t;
        end
    endfunction

    // Candidate per-frame positions and request acceptance.
    always_comb begin
        nx     = step_axis(px_q, tx_q);
        ny     = step_axis(py_q, ty_q);
        accept = (state_q == IDLE) && move_valid;
        arrive = (nx == tx_q) && (ny == ty_q);
    end

    // State and datapath registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            px_q    <= OX0;
            py_q    <= OY0;
            tx_q    <= '0;
            ty_q    <= '0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
        end
    end

    // Next-state logic: a tick that lands both axes on target ends the move.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = MOVE;
            MOVE:    if (frame_tick && arrive) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: snap to source on accept, step only on frame ticks.
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        tx_d = tx_q;
        ty_d = ty_q;
        if (accept) begin
            px_d = ox(src_col);
            py_d = oy(src_row);
            tx_d = ox(dst_col);
            ty_d = oy(dst_row);
        end else if (state_q == MOVE && frame_tick) begin
            px_d = nx;
            py_d = ny;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        move_ready = (state_q == IDLE);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        offsetX    = px_q;
        offsetY    = py_q;
    end

endmodule

// File: tb/tb_piece_move_animator.sv
// Self-checking bench for piece_move_animator: directed moves from the
// test list plus random moves against an arithmetic reference model.
module tb_piece_move_animator;

    localparam int X0 = 80;
    localparam int Y0 = 0;
    localparam int SQ = 60;
    localparam int PD = 2;
    localparam int ST = 4;

    logic       vga_clk;
    logic       reset_n;
    logic       frame_tick;
    logic       move_valid;
    logic       move_ready;
    logic [2:0] src_col, src_row, dst_col, dst_row;
    logic [9:0] offsetX, offsetY;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    piece_move_animator dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .src_col    (src_col),
        .src_row    (src_row),
        .dst_col    (dst_col),
        .dst_row    (dst_row),
        .offsetX    (offsetX),
        .offsetY    (offsetY),
        .busy       (busy),
        .done       (done)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sq_x(input int c);
        return X0 + c * SQ + PD;
    endfunction

    function automatic int sq_y(input int r);
        return Y0 + r * SQ + PD;
    endfunction

    // Position after k frame ticks: linear travel clipped at the target.
    function automatic int model_pos(input int s, input int t, input int k);
        int d, m;
        d = t - s;
        m = k * ST;
        if ((d < 0 ? -d : d) <= m) return t;
        return (d > 0) ? s + m : s - m;
    endfunction

    function automatic int model_ticks(input int sx, sy, tx, ty);
        int dx, dy, mx;
        dx = (tx > sx) ? tx - sx : sx - tx;
        dy = (ty > sy) ? ty - sy : sy - ty;
        mx = (dx > dy) ? dx : dy;
        mx = (mx + ST - 1) / ST;
        return (mx < 1) ? 1 : mx;
    endfunction

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    // Run one full move; hold keeps move_valid high with junk squares.
    task automatic do_move(
        input int sc, input int sr, input int dc, input int dr,
        input bit hold, input int max_gap
    );
        int sx, sy, tx, ty, n, w, gap;
        int ex, ey;
        sx = sq_x(sc); sy = sq_y(sr);
        tx = sq_x(dc); ty = sq_y(dr);
        n  = model_ticks(sx, sy, tx, ty);
        w  = 0;
        while (!move_ready && w < 20) begin
            cyc();
            w++;
        end
        check("ready_before_move", int'(move_ready), 1);
        src_col = 3'(sc); src_row = 3'(sr);
        dst_col = 3'(dc); dst_row = 3'(dr);
        move_valid = 1'b1;
        frame_tick = 1'($urandom_range(0, 1));
        cyc();
        frame_tick = 1'b0;
        move_valid = hold;
        src_col = 3'($urandom); src_row = 3'($urandom);
        dst_col = 3'($urandom); dst_row = 3'($urandom);
        check("accept_x", int'(offsetX), sx);
        check("accept_y", int'(offsetY), sy);
        check("accept_busy", int'(busy), 1);
        check("accept_ready", int'(move_ready), 0);
        for (int k = 1; k <= n; k++) begin
            gap = $urandom_range(0, max_gap);
            ex  = model_pos(sx, tx, k - 1);
            ey  = model_pos(sy, ty, k - 1);
            for (int g = 0; g < gap; g++) begin
                cyc();
                check("idle_x", int'(offsetX), ex);
                check("idle_y", int'(offsetY), ey);
                check("idle_done", int'(done), 0);
                check("idle_ready", int'(move_ready), 0);
            end
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            check("tick_x", int'(offsetX), model_pos(sx, tx, k));
            check("tick_y", int'(offsetY), model_pos(sy, ty, k));
            check("tick_done", int'(done), (k == n) ? 1 : 0);
            check("tick_busy", int'(busy), 1);
        end
        move_valid = 1'b0;
        cyc();
        check("post_done", int'(done), 0);
        check("post_ready", int'(move_ready), 1);
        check("post_busy", int'(busy), 0);
        check("post_x", int'(offsetX), tx);
        check("post_y", int'(offsetY), ty);
    endtask

    task automatic reset_mid_move();
        int seen;
        src_col = 3'd0; src_row = 3'd0;
        dst_col = 3'd5; dst_row = 3'd6;
        move_valid = 1'b1;
        cyc();
        move_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
        check("pre_rst_busy", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_x", int'(offsetX), 82);
        check("rst_y", int'(offsetY), 2);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(move_ready), 1);
        check("rst_done", int'(done), 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            frame_tick = 1'($urandom_range(0, 1));
            cyc();
            if (done) seen++;
        end
        frame_tick = 1'b0;
        check("rst_no_done", seen, 0);
        check("rst_hold_x", int'(offsetX), 82);
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        move_valid = 1'b0;
        src_col = '0; src_row = '0;
        dst_col = '0; dst_row = '0;
        #12;
        check("reset_x", int'(offsetX), 82);
        check("reset_y", int'(offsetY), 2);
        check("reset_ready", int'(move_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        cyc();

        do_move(0, 0, 0, 1, 1'b0, 2);
        do_move(0, 0, 7, 7, 1'b0, 1);
        check("d3_x", int'(offsetX), 502);
        check("d3_y", int'(offsetY), 422);
        do_move(1, 0, 2, 2, 1'b0, 2);
        check("d4_x", int'(offsetX), 202);
        check("d4_y", int'(offsetY), 122);
        do_move(3, 3, 3, 3, 1'b0, 2);
        check("d5_x", int'(offsetX), 262);
        check("d5_y", int'(offsetY), 182);
        do_move(2, 5, 6, 1, 1'b1, 2);

        reset_mid_move();

        for (int i = 0; i < 20; i++) begin
            do_move($urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
